blake2s_digest_buf: RTL and testbench

BLAKE2S_DIGEST_BUF -- requirements
Module: blake2s_digest_buf

---
 rtl/blake2s_digest_buf_pkg.sv | 24 ++
 rtl/blake2s_digest_buf_regfile.sv | 26 ++
 rtl/blake2s_digest_buf.sv | 122 ++++++++++++
 tb/tb_blake2s_digest_buf.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/blake2s_digest_buf_pkg.sv
// Shared BLAKE2s digest-buffer definitions: default digest size, counter width,
// FSM state encoding and the digest-length normalisation helper.
package blake2s_digest_buf_pkg;

    localparam int NN_MAX = 32;
    localparam int CNT_W  = 6;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    // A zero or oversized request means "full-size digest".
    function automatic cnt_t eff_len(cnt_t nn, int nn_max);
        if (nn == '0 || int'(nn) > nn_max) begin
            return cnt_t'(nn_max);
        end
        return nn;
    endfunction

endpackage

// File: rtl/blake2s_digest_buf_regfile.sv
// Digest byte store: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module digest_regfile #(
    parameter int DW    = 8,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/blake2s_digest_buf.sv
// Captures a BLAKE2s digest byte stream from the hash core and presents it
// byte by byte to the host; a new digest arriving mid-drain overwrites and flags ovf_o.
module blake2s_digest_buf #(
    parameter int DW     = 8,
    parameter int NN_MAX = blake2s_digest_buf_pkg::NN_MAX
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [5:0]    nn_i,
    input  logic          h_v_i,
    input  logic [DW-1:0] h_i,
    input  logic          rd_i,
    input  logic          clr_i,
    output logic          hash_v_o,
    output logic [DW-1:0] hash_o,
    output logic          busy_o,
    output logic          ovf_o
);

    import blake2s_digest_buf_pkg::*;

    localparam int AW = (NN_MAX > 1) ? $clog2(NN_MAX) : 1;

    state_t        state_reg;
    cnt_t          wr_cnt_reg;
    cnt_t          rd_cnt_reg;
    cnt_t          len_reg;
    logic          hash_v_reg;
    logic          busy_reg;
    logic          ovf_reg;

    cnt_t          nn_len;
    cnt_t          last_idx;
    logic          start;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] rd_data;

    assign nn_len   = eff_len(cnt_t'(nn_i), NN_MAX);
    assign last_idx = len_reg - cnt_t'(1);
    // Outside CAPTURE any valid byte is the first byte of a fresh digest.
    assign start    = h_v_i && (state_reg != ST_CAPTURE);
    assign wr_addr  = (state_reg == ST_CAPTURE) ? wr_cnt_reg[AW-1:0] : '0;

    digest_regfile #(
        .DW   (DW),
        .DEPTH(NN_MAX),
        .AW   (AW)
    ) u_regfile (
        .clk    (clk),
        .we     (h_v_i),
        .wr_addr(wr_addr),
        .wr_data(h_i),
        .rd_addr(rd_cnt_reg[AW-1:0]),
        .rd_data(rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            wr_cnt_reg <= '0;
            rd_cnt_reg <= '0;
            len_reg    <= cnt_t'(NN_MAX);
            hash_v_reg <= 1'b0;
            busy_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            // Overflow set takes precedence over a simultaneous clear.
            if (state_reg == ST_DRAIN && h_v_i) begin
                ovf_reg <= 1'b1;
            end else if (clr_i) begin
                ovf_reg <= 1'b0;
            end

            if (start) begin
                len_reg    <= nn_len;
                wr_cnt_reg <= cnt_t'(1);
                rd_cnt_reg <= '0;
                if (nn_len == cnt_t'(1)) begin
                    state_reg  <= ST_DRAIN;
                    hash_v_reg <= 1'b1;
                    busy_reg   <= 1'b0;
                end else begin
                    state_reg  <= ST_CAPTURE;
                    hash_v_reg <= 1'b0;
                    busy_reg   <= 1'b1;
                end
            end else begin
                case (state_reg)
                    ST_CAPTURE: begin
                        if (h_v_i) begin
                            if (wr_cnt_reg == last_idx) begin
                                state_reg  <= ST_DRAIN;
                                rd_cnt_reg <= '0;
                                hash_v_reg <= 1'b1;
                                busy_reg   <= 1'b0;
                            end else begin
                                wr_cnt_reg <= wr_cnt_reg + cnt_t'(1);
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (rd_i) begin
                            if (rd_cnt_reg == last_idx) begin
                                state_reg  <= ST_IDLE;
                                hash_v_reg <= 1'b0;
                            end else begin
                                rd_cnt_reg <= rd_cnt_reg + cnt_t'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign hash_v_o = hash_v_reg;
    assign hash_o   = hash_v_reg ? rd_data : '0;
    assign busy_o   = busy_reg;
    assign ovf_o    = ovf_reg;

endmodule

// File: tb/tb_blake2s_digest_buf.sv
// Directed-vector bench for blake2s_digest_buf: full, short, zero-length,
// overwrite, simultaneous-event and mid-capture-reset scenarios.
module tb_blake2s_digest_buf;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] nn_i = '0;
    logic       h_v_i = 1'b0;
    logic [7:0] h_i = '0;
    logic       rd_i = 1'b0;
    logic       clr_i = 1'b0;
    logic       hash_v_o;
    logic [7:0] hash_o;
    logic       busy_o;
    logic       ovf_o;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    blake2s_digest_buf #(
        .DW    (8),
        .NN_MAX(32)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .nn_i    (nn_i),
        .h_v_i   (h_v_i),
        .h_i     (h_i),
        .rd_i    (rd_i),
        .clr_i   (clr_i),
        .hash_v_o(hash_v_o),
        .hash_o  (hash_o),
        .busy_o  (busy_o),
        .ovf_o   (ovf_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_byte(input logic [7:0] b);
        h_v_i = 1'b1;
        h_i   = b;
        tick();
        h_v_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // reset state
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_hash_v", 32'(hash_v_o), 32'h0);
        check("rst_hash_o", 32'(hash_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_ovf", 32'(ovf_o), 32'h0);

        // full 32-byte digest, rd_i held high through the drain
        nn_i = 6'd32;
        for (int i = 0; i < 32; i++) begin
            put_byte(8'(i));
            if (i < 31) check("full_busy", 32'(busy_o), 32'h1);
        end
        check("full_busy_end", 32'(busy_o), 32'h0);
        check("full_valid", 32'(hash_v_o), 32'h1);
        rd_i = 1'b1;
        for (int i = 0; i < 32; i++) begin
            check("full_rd", 32'(hash_o), 32'(i));
            tick();
        end
        rd_i = 1'b0;
        check("full_done_v", 32'(hash_v_o), 32'h0);
        check("full_done_o", 32'(hash_o), 32'h0);

        // one-byte digest goes straight to DRAIN
        nn_i = 6'd1;
        put_byte(8'hA5);
        check("short_valid", 32'(hash_v_o), 32'h1);
        check("short_busy", 32'(busy_o), 32'h0);
        check("short_data", 32'(hash_o), 32'hA5);
        rd_i = 1'b1;
        tick();
        rd_i = 1'b0;
        check("short_done", 32'(hash_v_o), 32'h0);

        // nn_i = 0 means 32; nn_i changes after the first byte are ignored
        nn_i = 6'd0;
        put_byte(8'h40);
        nn_i = 6'd3;
        check("zero_busy", 32'(busy_o), 32'h1);
        for (int i = 1; i < 32; i++) begin
            put_byte(8'(8'h40 + i));
            if (i < 31) check("zero_busy", 32'(busy_o), 32'h1);
        end
        check("zero_busy_end", 32'(busy_o), 32'h0);
        check("zero_valid", 32'(hash_v_o), 32'h1);
        rd_i = 1'b1;
        for (int i = 0; i < 32; i++) begin
            check("zero_rd", 32'(hash_o), 32'(8'h40 + i));
            tick();
        end
        rd_i = 1'b0;
        check("zero_done", 32'(hash_v_o), 32'h0);

        // overwrite of a partly drained digest
        nn_i = 6'd4;
        put_byte(8'hA0);
        put_byte(8'hA1);
        put_byte(8'hA2);
        put_byte(8'hA3);
        check("ovw_first", 32'(hash_o), 32'hA0);
        rd_i = 1'b1;
        tick();
        check("ovw_second", 32'(hash_o), 32'hA1);
        tick();
        rd_i = 1'b0;
        check("ovw_third", 32'(hash_o), 32'hA2);
        tick();
        check("ovw_hold", 32'(hash_o), 32'hA2);
        check("ovw_ovf_pre", 32'(ovf_o), 32'h0);
        put_byte(8'h11);
        check("ovw_ovf", 32'(ovf_o), 32'h1);
        check("ovw_busy", 32'(busy_o), 32'h1);
        check("ovw_valid_lo", 32'(hash_v_o), 32'h0);
        put_byte(8'h22);
        put_byte(8'h33);
        put_byte(8'h44);
        check("ovw_valid", 32'(hash_v_o), 32'h1);
        rd_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("ovw_rd", 32'(hash_o), 32'(8'h11 * (i + 1)));
            tick();
        end
        rd_i = 1'b0;
        check("ovw_done", 32'(hash_v_o), 32'h0);
        check("ovw_ovf_sticky", 32'(ovf_o), 32'h1);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        check("ovw_clr", 32'(ovf_o), 32'h0);

        // h_v_i + rd_i + clr_i together in DRAIN: new byte wins, set beats clear
        nn_i = 6'd2;
        put_byte(8'h55);
        put_byte(8'h66);
        check("sim_drain", 32'(hash_o), 32'h55);
        h_v_i = 1'b1;
        h_i   = 8'h77;
        rd_i  = 1'b1;
        clr_i = 1'b1;
        tick();
        h_v_i = 1'b0;
        rd_i  = 1'b0;
        clr_i = 1'b0;
        check("sim_ovf", 32'(ovf_o), 32'h1);
        check("sim_busy", 32'(busy_o), 32'h1);
        put_byte(8'h88);
        check("sim_valid", 32'(hash_v_o), 32'h1);
        check("sim_mem0", 32'(hash_o), 32'h77);
        rd_i = 1'b1;
        tick();
        check("sim_mem1", 32'(hash_o), 32'h88);
        tick();
        rd_i = 1'b0;
        check("sim_done", 32'(hash_v_o), 32'h0);

        // reset after 10 of 32 bytes
        nn_i = 6'd32;
        for (int i = 0; i < 10; i++) begin
            put_byte(8'(8'h90 + i));
        end
        check("mid_busy", 32'(busy_o), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_v", 32'(hash_v_o), 32'h0);
        check("mid_rst_o", 32'(hash_o), 32'h0);
        check("mid_rst_busy", 32'(busy_o), 32'h0);
        check("mid_rst_ovf", 32'(ovf_o), 32'h0);
        rd_i = 1'b1;
        tick();
        rd_i = 1'b0;
        check("mid_idle_rd", 32'(hash_v_o), 32'h0);
        nn_i  = 6'd2;
        rd_i  = 1'b1;
        put_byte(8'hC1);
        put_byte(8'hC2);
        rd_i  = 1'b0;
        check("mid_valid", 32'(hash_v_o), 32'h1);
        check("mid_b0", 32'(hash_o), 32'hC1);
        tick();
        tick();
        check("mid_hold", 32'(hash_o), 32'hC1);
        rd_i = 1'b1;
        tick();
        check("mid_b1", 32'(hash_o), 32'hC2);
        tick();
        rd_i = 1'b0;
        check("mid_done", 32'(hash_v_o), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
